// File: rtl/sprite_anim_bitmap_pkg.sv
// sprite_pkg: shared types and constants for the animated sprite bitmap.
//   anim_state_t         - animation controller states
//   TRANSPARENT_ENCODING - pixel value meaning "draw nothing"
//   TRANSPARENT_ENCODING2- secondary (black) encoding excluded by drawingRequest2
//   HIT_TABLE            - 4x4 edge-hit codes {Left,Top,Right,Bottom}, [row][col]
//   DIR_*                - direction input encodings
//   sprite_pixel()       - stored bitmap test pattern used to fill the frame ROM
package sprite_pkg;

   typedef enum logic [1:0] {
      ST_ANIM   = 2'd0,
      ST_FREEZE = 2'd1,
      ST_DEATH  = 2'd2,
      ST_DEAD   = 2'd3
   } anim_state_t;

   localparam logic [7:0] TRANSPARENT_ENCODING  = 8'hFF;
   localparam logic [7:0] TRANSPARENT_ENCODING2 = 8'h00;

   // Row 0 is the top quarter of the sprite; nibble 0 (MSB) is the left quarter.
   localparam logic [0:3][0:3][3:0] HIT_TABLE = {16'hC446, 16'h8C62, 16'h8932, 16'h9113};

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   // Bitmap content: row/column/frame mixed so neighbouring pixels and frames differ.
   function automatic logic [7:0] sprite_pixel(input int unsigned frame,
                                                input int unsigned row,
                                                input int unsigned col);
      return 8'((row << 3) ^ col ^ (frame << 5));
   endfunction

endpackage

// File: rtl/sprite_anim_bitmap_ctrl.sv
// anim_frame_ctrl: chomp/death animation state machine.
//   clk, resetN            - clock, async active-low reset
//   startOfFrame           - one pulse per video frame, paces the animation
//   moving, dying          - animate/freeze request, death sequence request
//   direction              - live facing direction
//   frame_sel              - ROM frame to display, sampled at startOfFrame
//   rot_dir_c              - rotation to apply (latched direction during death)
//   death_done             - high while the last death frame is held
module anim_frame_ctrl
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_FRAMES   = 4,
   parameter int unsigned DEATH_FRAMES = 4,
   parameter int unsigned FRAME_HOLD   = 6,
   parameter int unsigned FSEL_W       = 3
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              startOfFrame,
   input  logic              moving,
   input  logic              dying,
   input  logic [1:0]        direction,
   output logic [FSEL_W-1:0] frame_sel,
   output logic [1:0]        rot_dir_c,
   output logic              death_done
);

   localparam int unsigned CNT_W = 6;
   localparam int unsigned IDX_W = 3;

   anim_state_t       state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt;
   logic              desc, desc_nxt;
   logic [1:0]        dir_lat, dir_lat_nxt;
   logic [FSEL_W-1:0] sel_nxt;
   logic              hold_wrap;

   // State register; displayed frame only moves on startOfFrame.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= ST_ANIM;
         cnt        <= '0;
         idx        <= '0;
         desc       <= 1'b0;
         dir_lat    <= DIR_RIGHT;
         frame_sel  <= '0;
         death_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         idx        <= idx_nxt;
         desc       <= desc_nxt;
         dir_lat    <= dir_lat_nxt;
         death_done <= (state_nxt == ST_DEAD);
         if (startOfFrame) frame_sel <= sel_nxt;
      end
   end

   // Next-state, hold counter and frame index.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      desc_nxt    = desc;
      dir_lat_nxt = dir_lat;
      hold_wrap   = (cnt == CNT_W'(FRAME_HOLD - 1));

      unique case (state)
         ST_ANIM, ST_FREEZE: begin
            if (dying) begin
               state_nxt   = ST_DEATH;
               cnt_nxt     = '0;
               idx_nxt     = '0;
               desc_nxt    = 1'b0;
               dir_lat_nxt = direction;
            end else if (state == ST_ANIM && !moving) begin
               state_nxt = ST_FREEZE;
            end else if (state == ST_FREEZE && moving) begin
               state_nxt = ST_ANIM;
            end else if (state == ST_ANIM && startOfFrame) begin
               if (hold_wrap) begin
                  cnt_nxt = '0;
                  // Ping-pong: turn around on reaching either endpoint so it is shown once.
                  if (!desc) begin
                     idx_nxt  = idx + IDX_W'(1);
                     desc_nxt = (idx == IDX_W'(NUM_FRAMES - 2));
                  end else begin
                     idx_nxt  = idx - IDX_W'(1);
                     desc_nxt = (idx != IDX_W'(1));
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         ST_DEATH: begin
            if (startOfFrame) begin
               if (hold_wrap) begin
                  cnt_nxt = '0;
                  if (idx == IDX_W'(DEATH_FRAMES - 1)) state_nxt = ST_DEAD;
                  else                                 idx_nxt   = idx + IDX_W'(1);
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         ST_DEAD: begin
            if (!dying) begin
               state_nxt = ST_ANIM;
               cnt_nxt   = '0;
               idx_nxt   = '0;
               desc_nxt  = 1'b0;
            end
         end
         default: state_nxt = ST_ANIM;
      endcase

      // Death frames sit after the chomp frames in the ROM.
      if (state_nxt == ST_DEATH || state_nxt == ST_DEAD)
         sel_nxt = FSEL_W'(NUM_FRAMES) + FSEL_W'(idx_nxt);
      else
         sel_nxt = FSEL_W'(idx_nxt);
   end

   assign rot_dir_c = (state == ST_DEATH || state == ST_DEAD) ? dir_lat : direction;

endmodule

// File: rtl/sprite_anim_bitmap.sv
// sprite_anim_bitmap: rotated, animated sprite pixel source.
//   clk, resetN                 - clock, async active-low reset
//   startOfFrame                - one pulse per video frame
//   offsetX, offsetY            - pixel offset from sprite top-left
//   InsideRectangle             - pixel lies inside the sprite bracket
//   direction, moving, dying    - facing, animate request, death request
//   RGBout, HitEdgeCode         - registered pixel colour and edge code (1 clock)
//   drawingRequest(2)           - decodes of RGBout against transparent encodings
//   deathDone                   - final death frame is being held
module sprite_anim_bitmap
   import sprite_pkg::*;
#(
   parameter int unsigned SIZE_BITS    = 5,
   parameter int unsigned NUM_FRAMES   = 4,
   parameter int unsigned DEATH_FRAMES = 4,
   parameter int unsigned FRAME_HOLD   = 6
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic [10:0] offsetX,
   input  logic [10:0] offsetY,
   input  logic        InsideRectangle,
   input  logic [1:0]  direction,
   input  logic        moving,
   input  logic        dying,
   output logic [7:0]  RGBout,
   output logic        drawingRequest,
   output logic        drawingRequest2,
   output logic [3:0]  HitEdgeCode,
   output logic        deathDone
);

   localparam int unsigned W      = 1 << SIZE_BITS;
   localparam int unsigned TOTAL  = NUM_FRAMES + DEATH_FRAMES;
   localparam int unsigned FSEL_W = $clog2(TOTAL);

   logic [FSEL_W-1:0]    frame_sel;
   logic [1:0]           rot_dir_c;
   logic [SIZE_BITS-1:0] x_c, y_c, row_c, col_c;
   logic                 in_range_c;
   logic [7:0]           rom [TOTAL][W][W];

   anim_frame_ctrl #(
      .NUM_FRAMES  (NUM_FRAMES),
      .DEATH_FRAMES(DEATH_FRAMES),
      .FRAME_HOLD  (FRAME_HOLD),
      .FSEL_W      (FSEL_W)
   ) u_ctrl (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(startOfFrame),
      .moving      (moving),
      .dying       (dying),
      .direction   (direction),
      .frame_sel   (frame_sel),
      .rot_dir_c   (rot_dir_c),
      .death_done  (deathDone)
   );

   // Frame ROM: chomp frames first, then death frames.
   for (genvar f = 0; f < TOTAL; f++) begin : g_frame
      for (genvar r = 0; r < W; r++) begin : g_row
         for (genvar c = 0; c < W; c++) begin : g_col
            assign rom[f][r][c] = sprite_pixel(f, r, c);
         end
      end
   end

   assign x_c        = offsetX[SIZE_BITS-1:0];
   assign y_c        = offsetY[SIZE_BITS-1:0];
   assign in_range_c = InsideRectangle && (offsetX < 11'(W)) && (offsetY < 11'(W));

   // Rotation; ~v equals W-1-v within SIZE_BITS.
   always_comb begin
      row_c = y_c;
      col_c = x_c;
      unique case (rot_dir_c)
         DIR_UP:    begin row_c = x_c;  col_c = ~y_c; end
         DIR_DOWN:  begin row_c = ~x_c; col_c = y_c;  end
         DIR_LEFT:  begin row_c = y_c;  col_c = ~x_c; end
         DIR_RIGHT: begin row_c = y_c;  col_c = x_c;  end
         default:   begin row_c = y_c;  col_c = x_c;  end
      endcase
   end

   // Pixel pipeline register; hit code uses unrotated offsets.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         RGBout      <= 8'h00;
         HitEdgeCode <= 4'h0;
      end else if (in_range_c) begin
         RGBout      <= rom[frame_sel][row_c][col_c];
         HitEdgeCode <= HIT_TABLE[y_c[SIZE_BITS-1 -: 2]][x_c[SIZE_BITS-1 -: 2]];
      end else begin
         RGBout      <= TRANSPARENT_ENCODING;
         HitEdgeCode <= 4'h0;
      end
   end

   assign drawingRequest  = (RGBout != TRANSPARENT_ENCODING);
   assign drawingRequest2 = drawingRequest && (RGBout != TRANSPARENT_ENCODING2);

endmodule

// File: tb/tb_sprite_anim_bitmap.sv
// Bench for sprite_anim_bitmap: two instances (FRAME_HOLD 2 and 1) share stimulus;
// a pulse-counting model predicts every output each cycle, and literal values
// pin the model at key points.
module tb_sprite_anim_bitmap;

   localparam int W  = 32;
   localparam int NF = 4;
   localparam int DF = 4;
   localparam int M_ANIM = 0, M_FREEZE = 1, M_DEATH = 2, M_DEAD = 3;

   logic        clk = 1'b0;
   logic        resetN, startOfFrame, InsideRectangle, moving, dying;
   logic [10:0] offsetX, offsetY;
   logic [1:0]  direction;
   logic [7:0]  rgb   [2];
   logic        dreq  [2];
   logic        dreq2 [2];
   logic        ddone [2];
   logic [3:0]  hit   [2];

   sprite_anim_bitmap #(.SIZE_BITS(5), .NUM_FRAMES(NF), .DEATH_FRAMES(DF), .FRAME_HOLD(2)) dut_a (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
      .direction(direction), .moving(moving), .dying(dying),
      .RGBout(rgb[0]), .drawingRequest(dreq[0]), .drawingRequest2(dreq2[0]),
      .HitEdgeCode(hit[0]), .deathDone(ddone[0]));

   sprite_anim_bitmap #(.SIZE_BITS(5), .NUM_FRAMES(NF), .DEATH_FRAMES(DF), .FRAME_HOLD(1)) dut_b (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
      .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
      .direction(direction), .moving(moving), .dying(dying),
      .RGBout(rgb[1]), .drawingRequest(dreq[1]), .drawingRequest2(dreq2[1]),
      .HitEdgeCode(hit[1]), .deathDone(ddone[1]));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model state: pulses counted in ANIM (ap) or DEATH (dp) drive the frame choice.
   int mmode   [2] = '{M_ANIM, M_ANIM};
   int ap      [2] = '{0, 0};
   int dp      [2] = '{0, 0};
   int mdir    [2] = '{3, 3};
   int mdisp   [2] = '{0, 0};
   int exp_rgb [2] = '{0, 0};
   int exp_hit [2] = '{0, 0};
   int exp_dd  [2] = '{0, 0};
   int hit_tab [4][4] = '{'{12, 4, 4, 6}, '{8, 12, 6, 2}, '{8, 9, 3, 2}, '{9, 1, 1, 3}};
   bit watch_done = 1'b0;
   bit done_after_rst = 1'b0;

   function automatic int stored_pixel(int f, int r, int c);
      return ((r * 8) ^ c ^ (f * 32)) & 255;
   endfunction

   function automatic int pingpong(int s);
      int p;
      p = s % (2 * NF - 2);
      return (p < NF) ? p : 2 * NF - 2 - p;
   endfunction

   function automatic int fh_of(int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic int frame_now(int k);
      case (mmode[k])
         M_DEATH: return NF + dp[k] / fh_of(k);
         M_DEAD:  return NF + DF - 1;
         default: return pingpong(ap[k] / fh_of(k));
      endcase
   endfunction

   task automatic model_reset(int k);
      mmode[k] = M_ANIM; ap[k] = 0; dp[k] = 0; mdir[k] = 3; mdisp[k] = 0;
      exp_rgb[k] = 0; exp_hit[k] = 0; exp_dd[k] = 0;
   endtask

   task automatic model_step(int k);
      int x, y, r, c, d;
      x = int'(offsetX);
      y = int'(offsetY);
      d = (mmode[k] >= M_DEATH) ? mdir[k] : int'(direction);
      r = 0;
      c = 0;
      if (InsideRectangle && x < W && y < W) begin
         case (d)
            0:       begin r = x;         c = W - 1 - y; end
            1:       begin r = W - 1 - x; c = y;         end
            2:       begin r = y;         c = W - 1 - x; end
            default: begin r = y;         c = x;         end
         endcase
         exp_rgb[k] = stored_pixel(mdisp[k], r, c);
         exp_hit[k] = hit_tab[y / 8][x / 8];
      end else begin
         exp_rgb[k] = 255;
         exp_hit[k] = 0;
      end
      case (mmode[k])
         M_ANIM, M_FREEZE: begin
            if (dying) begin
               mmode[k] = M_DEATH; dp[k] = 0; mdir[k] = int'(direction);
            end else if (mmode[k] == M_ANIM && !moving) mmode[k] = M_FREEZE;
            else if (mmode[k] == M_FREEZE && moving)    mmode[k] = M_ANIM;
            else if (mmode[k] == M_ANIM && startOfFrame) ap[k]++;
         end
         M_DEATH: if (startOfFrame) begin
            dp[k]++;
            if (dp[k] == fh_of(k) * DF) mmode[k] = M_DEAD;
         end
         default: if (!dying) begin
            mmode[k] = M_ANIM; ap[k] = 0;
         end
      endcase
      if (startOfFrame) mdisp[k] = frame_now(k);
      exp_dd[k] = (mmode[k] == M_DEAD) ? 1 : 0;
   endtask

   always @(posedge clk or negedge resetN) begin
      for (int k = 0; k < 2; k++) begin
         if (!resetN) model_reset(k);
         else         model_step(k);
      end
   end

   task automatic check(string name, int act, int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at t=%0t", name, act, want, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rgb%0d", k),   int'(rgb[k]),   exp_rgb[k]);
         check($sformatf("hit%0d", k),   int'(hit[k]),   exp_hit[k]);
         check($sformatf("drq%0d", k),   int'(dreq[k]),  (exp_rgb[k] != 255) ? 1 : 0);
         check($sformatf("drq2_%0d", k), int'(dreq2[k]), (exp_rgb[k] != 255 && exp_rgb[k] != 0) ? 1 : 0);
         check($sformatf("done%0d", k),  int'(ddone[k]), exp_dd[k]);
      end
      if (watch_done && (ddone[0] || ddone[1])) done_after_rst = 1'b1;
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic pulse();
      startOfFrame = 1'b1;
      cyc(1);
      startOfFrame = 1'b0;
      cyc(2);
   endtask

   task automatic probe(int x, int y);
      offsetX = 11'(x);
      offsetY = 11'(y);
      cyc(1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int chomp_exp [7] = '{11, 107, 75, 107, 11, 43, 11};
      resetN = 1'b0; startOfFrame = 1'b0; InsideRectangle = 1'b0;
      moving = 1'b1; dying = 1'b0; direction = 2'b11;
      offsetX = 11'd0; offsetY = 11'd0;
      cyc(3);
      check("rst_rgb", int'(rgb[0]), 0);
      check("rst_hit", int'(hit[0]), 0);
      check("rst_done", int'(ddone[0]), 0);
      check("rst_drq", int'(dreq[0]), 1);
      check("rst_drq2", int'(dreq2[0]), 0);
      resetN = 1'b1;
      cyc(2);

      // Chomp ping-pong, FRAME_HOLD=2 on dut_a, probe pixel (3,5) facing right.
      InsideRectangle = 1'b1;
      probe(3, 5);
      for (int p = 1; p <= 14; p++) begin
         pulse();
         if (p % 2 == 0) check($sformatf("chomp_p%0d", p), int'(rgb[0]), chomp_exp[p / 2 - 1]);
      end

      // Freeze for 5 pulses, then resume with the same counter phase.
      moving = 1'b0;
      cyc(2);
      repeat (5) pulse();
      check("freeze_hold", int'(rgb[0]), 11);
      moving = 1'b1;
      cyc(2);
      pulse();
      check("resume_phase", int'(rgb[0]), 11);
      pulse();
      check("resume_step", int'(rgb[0]), 107);

      // Rotations of (3,5) on chomp frame 2.
      direction = 2'b01; probe(3, 5); check("rot_down", int'(rgb[0]), 165);
      direction = 2'b00; probe(3, 5); check("rot_up", int'(rgb[0]), 66);
      direction = 2'b10; probe(3, 5); check("rot_left", int'(rgb[0]), 116);
      direction = 2'b11; probe(3, 5); check("rot_right", int'(rgb[0]), 107);

      // Bounds and hit codes.
      probe(40, 5);
      check("oob_rgb", int'(rgb[0]), 255);
      check("oob_drq", int'(dreq[0]), 0);
      probe(0, 0);
      check("hit_00", int'(hit[0]), 12);
      probe(31, 31);
      check("hit_3131", int'(hit[0]), 3);
      check("rgb_3131", int'(rgb[0]), 167);
      probe(32, 0);
      check("oob_x32", int'(rgb[0]), 255);
      InsideRectangle = 1'b0;
      probe(0, 0);
      check("outside_hit", int'(hit[0]), 0);
      InsideRectangle = 1'b1;

      // Death facing down; direction changes afterwards must not affect it.
      probe(3, 5);
      direction = 2'b01;
      dying = 1'b1;
      cyc(2);
      direction = 2'b11;
      repeat (3) pulse();
      check("death_b_p3", int'(ddone[1]), 0);
      pulse();
      check("death_b_p4", int'(ddone[1]), 1);
      check("death_b_rgb", int'(rgb[1]), 5);
      check("death_a_p4", int'(ddone[0]), 0);
      repeat (4) pulse();
      check("death_a_p8", int'(ddone[0]), 1);
      check("death_a_rgb", int'(rgb[0]), 5);
      dying = 1'b0;
      cyc(2);
      check("revive_done", int'(ddone[0]), 0);
      probe(0, 0);
      pulse();
      check("revive_rgb", int'(rgb[0]), 0);
      check("revive_drq", int'(dreq[0]), 1);
      check("revive_drq2", int'(dreq2[0]), 0);
      check("revive_b_rgb", int'(rgb[1]), 32);

      // Reset in the middle of death frame 2 (dut_b).
      probe(3, 5);
      dying = 1'b1;
      cyc(2);
      pulse();
      pulse();
      check("death2_rgb", int'(rgb[1]), 235);
      @(posedge clk);
      #2;
      resetN = 1'b0;
      watch_done = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("async_rgb%0d", k), int'(rgb[k]), 0);
         check($sformatf("async_hit%0d", k), int'(hit[k]), 0);
         check($sformatf("async_done%0d", k), int'(ddone[k]), 0);
      end
      cyc(3);
      dying = 1'b0;
      resetN = 1'b1;
      repeat (6) pulse();
      watch_done = 1'b0;
      check("no_done_after_rst", int'(done_after_rst), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sprite_anim_bitmap.md
SPRITE_ANIM_BITMAP -- requirements
Module: sprite_anim_bitmap

Interface
REQ-001 The block SHALL have parameter SIZE_BITS, default 5, sprite edge = 2^SIZE_BITS pixels (W).
REQ-002 The block SHALL have parameter NUM_FRAMES, default 4, number of chomp frames stored (frame 0 = mouth closed); legal range 2..8.
REQ-003 The block SHALL have parameter DEATH_FRAMES, default 4, number of death frames stored; legal range 1..8.
REQ-004 The block SHALL have parameter FRAME_HOLD, default 6, number of startOfFrame pulses per animation step; legal range 1..63.
REQ-005 The block SHALL have port clk, input, 1, system clock.
REQ-006 The block SHALL have port resetN, input, 1, one clock; reset is asynchronous and active-low.
REQ-007 The block SHALL have port startOfFrame, input, 1, single-cycle pulse once per video frame.
REQ-008 The block SHALL have port offsetX, input, 11, pixel X offset from sprite top-left.
REQ-009 The block SHALL have port offsetY, input, 11, pixel Y offset from sprite top-left.
REQ-010 The block SHALL have port InsideRectangle, input, 1, pixel lies inside sprite bracket.
REQ-011 The block SHALL have port direction, input, 2, 00 up, 01 down, 10 left, 11 right.
REQ-012 The block SHALL have port moving, input, 1, 1 = animate chomp, 0 = freeze.
REQ-013 The block SHALL have port dying, input, 1, level request to play the death sequence.
REQ-014 The block SHALL have port RGBout, output, 8, pixel colour.
REQ-015 The block SHALL have port drawingRequest, output, 1, RGBout != 8'hFF.
REQ-016 The block SHALL have port drawingRequest2, output, 1, RGBout not 8'hFF and not 8'h00.
REQ-017 The block SHALL have port HitEdgeCode, output, 4, {Left,Top,Right,Bottom}.
REQ-018 The block SHALL have port deathDone, output, 1, high while the final death frame is held.

Function
REQ-019 The block SHALL implement states ANIM, FREEZE, DEATH and DEAD.
REQ-020 ANIM SHALL go to FREEZE when moving=0, FREEZE SHALL go to ANIM when moving=1, and any state except DEAD SHALL go to DEATH when dying=1; dying has priority over moving.
REQ-021 On entry to DEATH, hold counter and frame index SHALL clear to 0, and direction SHALL be latched for the duration of DEATH/DEAD.
REQ-022 The hold counter SHALL increment only on startOfFrame; when it reaches FRAME_HOLD-1 it SHALL wrap to 0 and advance the frame index.
REQ-023 In ANIM the chomp index SHALL ping-pong 0,1,..,N-1,N-2,..,1,0 (N=NUM_FRAMES), with no repeated endpoint frames.
REQ-024 In FREEZE the counter and index SHALL hold their values.
REQ-025 In DEATH the index SHALL advance 0..DEATH_FRAMES-1 once, then the block SHALL enter DEAD.
REQ-026 In DEAD the block SHALL hold the last death frame and assert deathDone; it SHALL return to ANIM with index 0 when dying=0.
REQ-027 Frame index and state SHALL update only in the cycle of startOfFrame, or the cycle after a moving/dying change, and the displayed frame SHALL be sampled at startOfFrame so it never changes mid-frame.
REQ-028 Rotation SHALL map (x,y) to (row,col) as: right (y,x); left (y,W-1-x); up (x,W-1-y); down (W-1-x,y), using the low SIZE_BITS bits of the offsets.
REQ-029 Death frames SHALL use the rotation of the latched direction.
REQ-030 Pixel path latency SHALL be exactly 1 clock from offsetX/offsetY/InsideRectangle to RGBout/HitEdgeCode.
REQ-031 When InsideRectangle=0 or either offset >= W, RGBout SHALL be 8'hFF and HitEdgeCode SHALL be 0 on the next clock.
REQ-032 HitEdgeCode SHALL be indexed from the 4x4 table by [offsetY>>(SIZE_BITS-2)][offsetX>>(SIZE_BITS-2)] and SHALL be unrotated.
REQ-033 drawingRequest and drawingRequest2 SHALL be combinational decodes of registered RGBout.

Reset
REQ-034 During reset, RGBout SHALL be 8'h00, HitEdgeCode 0, deathDone 0, state ANIM, hold counter 0, frame index 0 and latched direction 2'b11.
REQ-035 Reset asserted mid-DEATH SHALL abort the sequence immediately with no deathDone pulse.

Structure
REQ-036 Package sprite_pkg SHALL hold the state enum, TRANSPARENT_ENCODING 8'hFF, TRANSPARENT_ENCODING2 8'h00, the hit table {16'hC446,16'h8C62,16'h8932,16'h9113} and the direction encodings.
REQ-037 Sub-module anim_frame_ctrl SHALL own the state machine, hold counter and frame index and export the frame select; the top level SHALL own the ROM arrays and pixel pipeline.
REQ-038 The frame ROM SHALL be one array of NUM_FRAMES+DEATH_FRAMES bitmaps, with death frames following chomp frames.

Verification
REQ-039 With FRAME_HOLD=2, NUM_FRAMES=4, moving=1 and 14 startOfFrame pulses, the index SHALL step 0,1,2,3,2,1,0,1 every 2nd pulse.
REQ-040 With moving=0 for 5 pulses and then 1, the index SHALL hold and then resume from the held value with the same counter phase.
REQ-041 Asserting dying=1 in ANIM with FRAME_HOLD=1 and DEATH_FRAMES=4 SHALL give deathDone=1 after the 4th pulse; dying=0 SHALL then return the block to ANIM at index 0.
REQ-042 With direction=01, offsetX=3, offsetY=5 and a unique-valued bitmap, RGBout SHALL equal frame[row 28][col 5] one clock later; repeat for all four directions.
REQ-043 InsideRectangle=1 with offsetX=40 SHALL give RGBout=8'hFF and drawingRequest=0; offset (0,0) inside SHALL give HitEdgeCode=4'hC.
REQ-044 resetN low during DEATH frame 2 SHALL give all outputs at reset values asynchronously and deathDone never asserted.
